// File: rtl/mux_arb.sv
// Two-requester round-robin arbiter for the shared registered mux32 operand path.
// Optional burst locking is compiled in with `define MUX_ARB_LOCK_EN.
module mux_arb #(
  parameter logic [3:0] BURST_MAX = 4'd4
) (
  input  logic c,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1,
  output logic s,
  output logic vld,
  output logic vid,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   r_s;
  logic   r_vld;
  logic   r_vid;

`ifdef MUX_ARB_LOCK_EN
  logic [3:0] r_burst;
  logic [3:0] w_burst_next;
  logic       w_other_req;
`else
  logic       w_lock_unused;
  assign w_lock_unused = ^{lock0, lock1, BURST_MAX};
`endif

  // Next-state: round robin on ties, with the burst lock overriding it while owned.
  always_comb begin
    w_next = IDLE;
    if (req0 && req1) begin
      w_next = r_last ? G0 : G1;
    end else if (req0) begin
      w_next = G0;
    end else if (req1) begin
      w_next = G1;
    end
`ifdef MUX_ARB_LOCK_EN
    if ((r_state == G0) && req0 && lock0 && !(req1 && (r_burst == BURST_MAX))) begin
      w_next = G0;
    end
    if ((r_state == G1) && req1 && lock1 && !(req0 && (r_burst == BURST_MAX))) begin
      w_next = G1;
    end
`endif
  end

`ifdef MUX_ARB_LOCK_EN
  // Counts grants to the same owner only while the other side is waiting.
  always_comb begin
    w_other_req  = 1'b0;
    w_burst_next = 4'd0;
    if (w_next == G0) begin
      w_other_req = req1;
    end else if (w_next == G1) begin
      w_other_req = req0;
    end
    if (w_other_req) begin
      w_burst_next = (w_next == r_state) ? (r_burst + 4'd1) : 4'd1;
    end
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_burst <= 4'd0;
    end else begin
      r_burst <= w_burst_next;
    end
  end
`endif

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_s     <= 1'b0;
      r_vld   <= 1'b0;
      r_vid   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == G0) begin
        r_s    <= 1'b0;
        r_last <= 1'b0;
      end else if (w_next == G1) begin
        r_s    <= 1'b1;
        r_last <= 1'b1;
      end
      // Result strobe tracks the one-cycle mux32 output register.
      r_vld <= (r_state != IDLE);
      r_vid <= r_s;
    end
  end

  assign gnt0 = (r_state == G0);
  assign gnt1 = (r_state == G1);
  assign s    = r_s;
  assign vld  = r_vld;
  assign vid  = r_vid;
  assign busy = gnt0 | gnt1 | r_vld;

endmodule
